// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter and busy scoreboard.
// Merges ALU and LSU writebacks onto the single regfile write port, tracks
// destinations with outstanding writes so decode can stall on RAW hazards,
// and flags writeback/issue protocol violations with a sticky error bit.
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [AW-1:0]       alu_addr,
    input  logic [XLEN-1:0]     alu_data,
    output logic                alu_ready,
    input  logic                lsu_valid,
    input  logic [AW-1:0]       lsu_addr,
    input  logic [XLEN-1:0]     lsu_data,
    output logic                lsu_ready,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic [AW-1:0]       rs1_addr,
    input  logic [AW-1:0]       rs2_addr,
    output logic                raw_stall,
    output logic                RegWEnSelect,
    output logic [AW-1:0]       wrAddr,
    output logic [XLEN-1:0]     wrData,
    output logic [(1<<AW)-1:0]  busy_vec,
    output logic                proto_err
);

    localparam int NREG = 1 << AW;
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0]      starve_cnt;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;

    logic            lsu_win;
    logic            grant;
    logic [AW-1:0]   gnt_addr;
    logic [XLEN-1:0] gnt_data;

    logic            err_issue;
    logic            err_write;
    logic            err_same;

    // ------------------------------------------------------------------
    // Arbitration: ALU has priority unless the LSU has lost STARVE_MAX
    // consecutive contended cycles, in which case it takes one grant.
    // ------------------------------------------------------------------
    assign lsu_win   = lsu_valid && (!alu_valid || (starve_cnt == STARVE_LIM));
    assign lsu_ready = lsu_win;
    assign alu_ready = alu_valid && !lsu_win;
    assign grant     = alu_valid || lsu_valid;

    // Select the winning request's address and data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        gnt_addr = alu_addr;
        gnt_data = alu_data;
        if (lsu_win) begin
            gnt_addr = lsu_addr;
            gnt_data = lsu_data;
        end
    end

    // Starvation counter: count LSU losses, clear on an LSU grant, hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (lsu_valid) begin
            if (lsu_win) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    // Register the granted write; x0 writes are accepted but never enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWEnSelect <= 1'b0;
            wrAddr       <= '0;
            wrData       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            RegWEnSelect <= grant && (gnt_addr != '0);
            if (grant) begin
                wrAddr <= gnt_addr;
                wrData <= gnt_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: the write in flight clears its bit at the end of the
    // enable cycle; an issue to the same register on that edge wins.
    // ------------------------------------------------------------------
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (RegWEnSelect) begin
            clr_mask[wrAddr] = 1'b1;
        end
        if (iss_valid && (iss_rd != '0)) begin
            set_mask[iss_rd] = 1'b1;
        end
        busy_next    = (busy_q & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    // Busy bits update on every edge from the set/clear masks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_vec = busy_q;

    // No bypass: a register whose write completes this cycle still stalls.
    assign raw_stall = ((rs1_addr != '0) && busy_q[rs1_addr]) ||
                       ((rs2_addr != '0) && busy_q[rs2_addr]);

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    assign err_issue = iss_valid && (iss_rd != '0) && busy_q[iss_rd] && !clr_mask[iss_rd];
    assign err_write = grant && (gnt_addr != '0) && !busy_q[gnt_addr];
    assign err_same  = alu_valid && lsu_valid && (alu_addr == lsu_addr) && (alu_addr != '0);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proto_err <= 1'b0;
        end else if (err_issue || err_write || err_same) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes each expected
// regfile write into a queue; a monitor pops and compares whenever the
// DUT drives RegWEnSelect.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, lsu_valid, iss_valid;
    logic [4:0]  alu_addr, lsu_addr, iss_rd, rs1_addr, rs2_addr;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, raw_stall, RegWEnSelect, proto_err;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [31:0] busy_vec;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    regfile_wb_arbiter #(.XLEN(32), .AW(5), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .raw_stall(raw_stall), .RegWEnSelect(RegWEnSelect), .wrAddr(wrAddr), .wrData(wrData),
        .busy_vec(busy_vec), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every enabled write must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && RegWEnSelect) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, wrAddr}, 64'hFFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", wrAddr, w.addr);
                check("wr_data", wrData, w.data);
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  t3_alu [5];
        logic        t3_lsu [5];
        t3_alu = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd13};
        t3_lsu = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
        iss_valid = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
        step(); step();
        check("rst_wen", RegWEnSelect, 0);
        check("rst_addr", wrAddr, 0);
        check("rst_data", wrData, 0);
        check("rst_busy", busy_vec, 0);
        check("rst_proto", proto_err, 0);
        reset = 1'b1;
        step();

        // Test 1: reset asserted while a write is enabled.
        iss_valid = 1; iss_rd = 5'd3;
        step();
        iss_valid = 0;
        alu_valid = 1; alu_addr = 5'd3; alu_data = 32'h1111_1111;
        #1 check("t1_alu_ready", alu_ready, 1);
        step();
        alu_valid = 0;
        check("t1_wen_pre", RegWEnSelect, 1);
        check("t1_busy_pre", busy_vec, 32'h0000_0008);
        #1 reset = 1'b0;
        #1;
        check("t1_wen_rst", RegWEnSelect, 0);
        check("t1_busy_rst", busy_vec, 0);
        check("t1_addr_rst", wrAddr, 0);
        step();
        reset = 1'b1;
        step();

        // Test 2: issue rd=5, write it back, stall on rs1=5 throughout.
        iss_valid = 1; iss_rd = 5'd5; rs1_addr = 5'd5;
        #1 check("t2_stall0", raw_stall, 0);
        step();
        iss_valid = 0;
        alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
        push(5'd5, 32'hDEAD_BEEF);
        #1;
        check("t2_alu_ready", alu_ready, 1);
        check("t2_lsu_ready", lsu_ready, 0);
        check("t2_stall1", raw_stall, 1);
        check("t2_busy1", busy_vec[5], 1);
        step();
        alu_valid = 0;
        #1;
        check("t2_wen", RegWEnSelect, 1);
        check("t2_stall2", raw_stall, 1);
        check("t2_busy2", busy_vec[5], 1);
        step();
        check("t2_busy3", busy_vec[5], 0);
        check("t2_stall3", raw_stall, 0);
        rs1_addr = 0;

        // Test 3: contended arbitration A,A,A,L,A.
        for (int i = 0; i < 5; i++) begin
            iss_valid = 1;
            iss_rd = (i == 4) ? 5'd20 : 5'd10 + 5'(i);
            step();
        end
        iss_valid = 0;
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1; alu_addr = t3_alu[i]; alu_data = 32'hA000_0000 | 32'(t3_alu[i]);
            lsu_valid = 1; lsu_addr = 5'd20;     lsu_data = 32'h2020_2020;
            #1;
            check($sformatf("t3_alu_ready%0d", i), alu_ready, !t3_lsu[i]);
            check($sformatf("t3_lsu_ready%0d", i), lsu_ready, t3_lsu[i]);
            if (t3_lsu[i]) push(5'd20, 32'h2020_2020);
            else           push(t3_alu[i], 32'hA000_0000 | 32'(t3_alu[i]));
            step();
        end
        alu_valid = 0; lsu_valid = 0;
        step(); step(); step();
        check("t3_busy_drained", busy_vec, 0);
        check("t3_proto", proto_err, 0);

        // Test 4: x0 write accepted but never enabled; issue to x0 ignored.
        alu_valid = 1; alu_addr = 5'd0; alu_data = 32'h0000_0055;
        iss_valid = 1; iss_rd = 5'd0;
        #1 check("t4_alu_ready", alu_ready, 1);
        step();
        alu_valid = 0; iss_valid = 0;
        #1 check("t4_wen", RegWEnSelect, 0);
        step();
        check("t4_busy", busy_vec, 0);
        check("t4_proto", proto_err, 0);

        // Test 5: issue during the clearing write wins; double issue is an error.
        iss_valid = 1; iss_rd = 5'd7;
        step();
        iss_valid = 0;
        alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h0000_0777;
        push(5'd7, 32'h0000_0777);
        step();
        alu_valid = 0;
        iss_valid = 1; iss_rd = 5'd7;
        #1;
        check("t5_wen", RegWEnSelect, 1);
        check("t5_wraddr", wrAddr, 5'd7);
        step();
        iss_valid = 0;
        #1;
        check("t5_busy7", busy_vec[7], 1);
        check("t5_proto0", proto_err, 0);
        iss_valid = 1; iss_rd = 5'd9;
        step();
        step();
        iss_valid = 0;
        #1 check("t5_proto1", proto_err, 1);
        step(); step();
        check("t5_proto_sticky", proto_err, 1);
        check("t5_busy_final", busy_vec, 32'h0000_0280);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
